// File: rtl/apb_timer_slave.sv
// -----------------------------------------------------------------------------
// apb_timer_slave
//
// Zero-wait-state APB slave hosting a prescaled down-counter timer with
// optional auto-reload and a level interrupt.
//
// Ports:
//   H_CLK      clock shared with the upstream AHB-to-APB bridge
//   H_RESET    synchronous, active-high reset
//   P_SELx     APB select
//   P_ENABLE   APB enable (access phase)
//   P_WRITE    1 = write, 0 = read
//   P_ADDR     byte address, only [4:2] selects a register
//   P_WDATA    write data
//   P_RDATA    read data, combinational during setup and access phases
//   P_SLVERR   unmapped-address error, asserted in the access phase
//   TIMER_IRQ  registered level interrupt (IRQ_PEND & IRQ_EN)
//
// Register map (P_ADDR[4:2]):
//   0 CTRL   [0] EN, [1] AUTO_RELOAD, [2] IRQ_EN, [15:8] PRESCALE
//   1 LOAD   reload value
//   2 COUNT  current count, writes load the counter directly
//   3 STATUS [0] IRQ_PEND (W1C), [1] PROT_ERR (sticky, W1C)
//   4 ID     read-only constant
//   5-7      unmapped, read 0, writes ignored, P_SLVERR in access phase
// -----------------------------------------------------------------------------
module apb_timer_slave #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE   = DATA_WIDTH'(32'hA7B0_0001)
) (
    input  logic                  H_CLK,
    input  logic                  H_RESET,
    input  logic                  P_SELx,
    input  logic                  P_ENABLE,
    input  logic                  P_WRITE,
    input  logic [ADDR_WIDTH-1:0] P_ADDR,
    input  logic [DATA_WIDTH-1:0] P_WDATA,
    output logic [DATA_WIDTH-1:0] P_RDATA,
    output logic                  P_SLVERR,
    output logic                  TIMER_IRQ
);

    // The state lags the bus by one cycle: SETUP means the previous cycle
    // was a setup phase, so the current cycle may be the matching access.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [ADDR_WIDTH-1:0]   r_addr_q;
    logic                    r_write_q;

    logic                    r_en;
    logic                    r_auto_reload;
    logic                    r_irq_en;
    logic [7:0]              r_prescale;
    logic [DATA_WIDTH-1:0]   r_load;
    logic [DATA_WIDTH-1:0]   r_count;
    logic                    r_irq_pend;
    logic                    r_prot_err;
    logic [7:0]              r_presc_cnt;
    logic                    r_timer_irq;

    logic                    w_acc_ok;
    logic                    w_prot_err;
    logic                    w_addr_chg;
    logic                    w_wr_commit;
    logic [2:0]              w_reg_sel;
    logic                    w_wr_ctrl;
    logic                    w_wr_load;
    logic                    w_wr_count;
    logic                    w_wr_status;
    logic                    w_tick;
    logic                    w_expire;

    logic                    w_en_nxt;
    logic                    w_auto_reload_nxt;
    logic                    w_irq_en_nxt;
    logic [7:0]              w_prescale_nxt;
    logic [DATA_WIDTH-1:0]   w_count_nxt;
    logic                    w_irq_pend_nxt;
    logic                    w_prot_err_nxt;
    logic [7:0]              w_presc_cnt_nxt;
    logic [DATA_WIDTH-1:0]   w_rdata;

    assign w_reg_sel   = P_ADDR[4:2];
    assign w_addr_chg  = (P_ADDR != r_addr_q) || (P_WRITE != r_write_q);
    assign w_wr_commit = w_acc_ok && P_WRITE;
    assign w_wr_ctrl   = w_wr_commit && (w_reg_sel == 3'd0);
    assign w_wr_load   = w_wr_commit && (w_reg_sel == 3'd1);
    assign w_wr_count  = w_wr_commit && (w_reg_sel == 3'd2);
    assign w_wr_status = w_wr_commit && (w_reg_sel == 3'd3);
    assign w_tick      = r_en && (r_presc_cnt == r_prescale);
    assign w_expire    = w_tick && (r_count == '0);

    // APB phase state register
    always_ff @(posedge H_CLK) begin
        if (H_RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // APB phase next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (P_SELx && !P_ENABLE) w_state_nxt = ST_SETUP;
                else                     w_state_nxt = ST_IDLE;
            end
            ST_SETUP: begin
                if (!P_SELx)        w_state_nxt = ST_IDLE;
                else if (P_ENABLE)  w_state_nxt = ST_ACCESS;
                else                w_state_nxt = ST_SETUP;
            end
            ST_ACCESS: begin
                if (P_SELx && !P_ENABLE) w_state_nxt = ST_SETUP;
                else                     w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // APB phase outputs: valid access qualifier and protocol error
    always_comb begin
        w_acc_ok   = 1'b0;
        w_prot_err = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_prot_err = P_ENABLE;
            end
            ST_SETUP: begin
                if (P_SELx && P_ENABLE) begin
                    w_acc_ok   = !w_addr_chg;
                    w_prot_err = w_addr_chg;
                end else begin
                    w_acc_ok   = 1'b0;
                    w_prot_err = 1'b0;
                end
            end
            ST_ACCESS: begin
                w_acc_ok   = 1'b0;
                w_prot_err = 1'b0;
            end
            default: begin
                w_acc_ok   = 1'b0;
                w_prot_err = 1'b0;
            end
        endcase
    end

    // Capture the setup-phase address/direction for the access-phase compare
    always_ff @(posedge H_CLK) begin
        if (H_RESET) begin
            r_addr_q  <= '0;
            r_write_q <= 1'b0;
        end else if (P_SELx && !P_ENABLE) begin
            r_addr_q  <= P_ADDR;
            r_write_q <= P_WRITE;
        end else begin
            r_addr_q  <= r_addr_q;
            r_write_q <= r_write_q;
        end
    end

    // Next-state of the register bank: bus writes first, then timer events
    always_comb begin
        w_en_nxt          = r_en;
        w_auto_reload_nxt = r_auto_reload;
        w_irq_en_nxt      = r_irq_en;
        w_prescale_nxt    = r_prescale;
        w_count_nxt       = r_count;
        w_irq_pend_nxt    = r_irq_pend;
        w_prot_err_nxt    = r_prot_err;
        w_presc_cnt_nxt   = r_presc_cnt;

        if (w_wr_ctrl) begin
            w_en_nxt          = P_WDATA[0];
            w_auto_reload_nxt = P_WDATA[1];
            w_irq_en_nxt      = P_WDATA[2];
            w_prescale_nxt    = P_WDATA[15:8];
        end else begin
            w_en_nxt          = r_en;
            w_auto_reload_nxt = r_auto_reload;
        end

        // Expiry without reload stops the timer, even over a fresh EN=1 write
        if (w_expire && !w_auto_reload_nxt) begin
            w_en_nxt = 1'b0;
        end else begin
            w_en_nxt = w_en_nxt;
        end

        // A bus write to COUNT beats any same-cycle decrement or reload
        if (w_wr_count) begin
            w_count_nxt = P_WDATA;
        end else if (w_tick) begin
            if (r_count != '0)          w_count_nxt = r_count - DATA_WIDTH'(1);
            else if (w_auto_reload_nxt) w_count_nxt = r_load;
            else                        w_count_nxt = '0;
        end else begin
            w_count_nxt = r_count;
        end

        // W1C is applied first so a same-cycle hardware set wins
        if (w_wr_status && P_WDATA[0]) w_irq_pend_nxt = 1'b0;
        else                           w_irq_pend_nxt = r_irq_pend;
        if (w_expire)                  w_irq_pend_nxt = 1'b1;
        else                           w_irq_pend_nxt = w_irq_pend_nxt;

        if (w_wr_status && P_WDATA[1]) w_prot_err_nxt = 1'b0;
        else                           w_prot_err_nxt = r_prot_err;
        if (w_prot_err)                w_prot_err_nxt = 1'b1;
        else                           w_prot_err_nxt = w_prot_err_nxt;

        if (w_wr_ctrl || !r_en || w_tick) w_presc_cnt_nxt = 8'd0;
        else                              w_presc_cnt_nxt = r_presc_cnt + 8'd1;
    end

    // Register bank and timer state
    always_ff @(posedge H_CLK) begin
        if (H_RESET) begin
            r_en          <= 1'b0;
            r_auto_reload <= 1'b0;
            r_irq_en      <= 1'b0;
            r_prescale    <= 8'd0;
            r_load        <= '0;
            r_count       <= '0;
            r_irq_pend    <= 1'b0;
            r_prot_err    <= 1'b0;
            r_presc_cnt   <= 8'd0;
        end else begin
            r_en          <= w_en_nxt;
            r_auto_reload <= w_auto_reload_nxt;
            r_irq_en      <= w_irq_en_nxt;
            r_prescale    <= w_prescale_nxt;
            r_load        <= w_wr_load ? P_WDATA : r_load;
            r_count       <= w_count_nxt;
            r_irq_pend    <= w_irq_pend_nxt;
            r_prot_err    <= w_prot_err_nxt;
            r_presc_cnt   <= w_presc_cnt_nxt;
        end
    end

    // Interrupt output, one cycle behind the pending/enable bits
    always_ff @(posedge H_CLK) begin
        if (H_RESET) begin
            r_timer_irq <= 1'b0;
        end else begin
            r_timer_irq <= r_irq_pend && r_irq_en;
        end
    end

    // Read mux, live in both setup and access phases for zero wait states
    always_comb begin
        w_rdata = '0;
        if (P_SELx && !P_WRITE) begin
            case (w_reg_sel)
                3'd0: begin
                    w_rdata[0]    = r_en;
                    w_rdata[1]    = r_auto_reload;
                    w_rdata[2]    = r_irq_en;
                    w_rdata[15:8] = r_prescale;
                end
                3'd1: w_rdata = r_load;
                3'd2: w_rdata = r_count;
                3'd3: begin
                    w_rdata[0] = r_irq_pend;
                    w_rdata[1] = r_prot_err;
                end
                3'd4:    w_rdata = ID_VALUE;
                default: w_rdata = '0;
            endcase
        end else begin
            w_rdata = '0;
        end
    end

    assign P_RDATA   = w_rdata;
    assign P_SLVERR  = P_SELx && P_ENABLE && (w_reg_sel > 3'd4);
    assign TIMER_IRQ = r_timer_irq;

endmodule

// File: tb/tb_apb_timer_slave.sv
// -----------------------------------------------------------------------------
// tb_apb_timer_slave
//
// Directed bench for apb_timer_slave. A bus-history model of the register
// bank predicts P_RDATA, P_SLVERR and TIMER_IRQ every cycle; hand-computed
// literals pin the important points of each scenario.
// -----------------------------------------------------------------------------
module tb_apb_timer_slave;

    logic        H_CLK;
    logic        H_RESET;
    logic        P_SELx;
    logic        P_ENABLE;
    logic        P_WRITE;
    logic [31:0] P_ADDR;
    logic [31:0] P_WDATA;
    logic [31:0] P_RDATA;
    logic        P_SLVERR;
    logic        TIMER_IRQ;

    int checks = 0;
    int errors = 0;
    logic cmp_en;

    apb_timer_slave dut (
        .H_CLK     (H_CLK),
        .H_RESET   (H_RESET),
        .P_SELx    (P_SELx),
        .P_ENABLE  (P_ENABLE),
        .P_WRITE   (P_WRITE),
        .P_ADDR    (P_ADDR),
        .P_WDATA   (P_WDATA),
        .P_RDATA   (P_RDATA),
        .P_SLVERR  (P_SLVERR),
        .TIMER_IRQ (TIMER_IRQ)
    );

    initial H_CLK = 1'b0;
    always #5 H_CLK = ~H_CLK;

    // Model state: architectural registers plus what the bus did last cycle
    typedef struct packed {
        logic        en;
        logic        ar;
        logic        ie;
        logic [7:0]  ps;
        logic [31:0] load;
        logic [31:0] count;
        logic        pend;
        logic        perr;
        logic [7:0]  pc;
        logic        irq;
        logic        prev_setup;
        logic        prev_access;
        logic [31:0] prev_addr;
        logic        prev_write;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t model_next(input mstate_t s, input logic rst,
                                           input logic sel, input logic en,
                                           input logic wr, input logic [31:0] addr,
                                           input logic [31:0] wdata);
        mstate_t n;
        logic setup_now, acc_now, changed, perr, wc, tick, expire;
        logic [2:0] r;
        n = s;
        if (rst) begin
            n = '0;
            return n;
        end
        setup_now = sel && !en;
        acc_now   = sel && en;
        changed   = (addr != s.prev_addr) || (wr != s.prev_write);
        perr      = (en && !s.prev_setup && !s.prev_access) ||
                    (acc_now && s.prev_setup && changed);
        wc        = acc_now && wr && s.prev_setup && !changed;
        r         = addr[4:2];
        tick      = s.en && (s.pc == s.ps);
        expire    = tick && (s.count == 32'd0);

        n.pc = (!s.en || tick || (wc && r == 3'd0)) ? 8'd0 : s.pc + 8'd1;
        if (wc && r == 3'd0) begin
            n.en = wdata[0];
            n.ar = wdata[1];
            n.ie = wdata[2];
            n.ps = wdata[15:8];
        end
        if (wc && r == 3'd1) n.load = wdata;
        if (tick && !expire) n.count = s.count - 32'd1;
        if (expire) begin
            if (n.ar) n.count = s.load;
            else begin
                n.count = 32'd0;
                n.en    = 1'b0;
            end
        end
        if (wc && r == 3'd2) n.count = wdata;
        if (wc && r == 3'd3 && wdata[0]) n.pend = 1'b0;
        if (wc && r == 3'd3 && wdata[1]) n.perr = 1'b0;
        if (expire) n.pend = 1'b1;
        if (perr)   n.perr = 1'b1;
        n.irq         = s.pend && s.ie;
        n.prev_setup  = setup_now;
        n.prev_access = acc_now && s.prev_setup;
        n.prev_addr   = addr;
        n.prev_write  = wr;
        return n;
    endfunction

    function automatic logic [31:0] model_read(input mstate_t s, input logic [31:0] addr);
        case (addr[4:2])
            3'd0:    return {16'h0000, s.ps, 5'b00000, s.ie, s.ar, s.en};
            3'd1:    return s.load;
            3'd2:    return s.count;
            3'd3:    return {30'd0, s.perr, s.pend};
            3'd4:    return 32'hA7B0_0001;
            default: return 32'h0000_0000;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge H_CLK) begin
        m <= model_next(m, H_RESET, P_SELx, P_ENABLE, P_WRITE, P_ADDR, P_WDATA);
    end

    // Per-cycle compare against the model
    always @(negedge H_CLK) begin
        if (cmp_en) begin
            check("rdata", P_RDATA, (P_SELx && !P_WRITE) ? model_read(m, P_ADDR) : 32'd0);
            check("slverr", {31'd0, P_SLVERR},
                  {31'd0, P_SELx && P_ENABLE && (P_ADDR[4:2] > 3'd4)});
            check("irq", {31'd0, TIMER_IRQ}, {31'd0, m.irq});
        end
    end

    task automatic bus_idle(input int n);
        for (int i = 0; i < n; i++) begin
            P_SELx = 1'b0; P_ENABLE = 1'b0; P_WRITE = 1'b0;
            @(posedge H_CLK); #1;
        end
    endtask

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
        P_SELx = 1'b1; P_ENABLE = 1'b0; P_WRITE = 1'b1; P_ADDR = addr; P_WDATA = data;
        @(posedge H_CLK); #1;
        P_ENABLE = 1'b1;
        @(posedge H_CLK); #1;
        P_SELx = 1'b0; P_ENABLE = 1'b0; P_WRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] rs,
                            output logic [31:0] ra, output logic slv);
        P_SELx = 1'b1; P_ENABLE = 1'b0; P_WRITE = 1'b0; P_ADDR = addr;
        @(negedge H_CLK); rs = P_RDATA;
        @(posedge H_CLK); #1;
        P_ENABLE = 1'b1;
        @(negedge H_CLK); ra = P_RDATA; slv = P_SLVERR;
        @(posedge H_CLK); #1;
        P_SELx = 1'b0; P_ENABLE = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rs, ra;
        logic        slv;
        cmp_en = 1'b0;
        H_RESET = 1'b1; P_SELx = 1'b0; P_ENABLE = 1'b0; P_WRITE = 1'b0;
        P_ADDR = 32'd0; P_WDATA = 32'd0;
        repeat (2) @(posedge H_CLK);
        #1 H_RESET = 1'b0;
        cmp_en = 1'b1;

        // Reset state
        @(negedge H_CLK);
        check("rst_rdata", P_RDATA, 32'd0);
        check("rst_slverr", {31'd0, P_SLVERR}, 32'd0);
        check("rst_irq", {31'd0, TIMER_IRQ}, 32'd0);
        @(posedge H_CLK); #1;

        // 1: ID register
        apb_read(32'h10, rs, ra, slv);
        check("id_setup", rs, 32'hA7B0_0001);
        check("id_access", ra, 32'hA7B0_0001);
        check("id_slverr", {31'd0, slv}, 32'd0);

        // 2: auto-reload with PRESCALE=0, sequence 3,2,1,0,3
        apb_write(32'h4, 32'd3);
        apb_write(32'h8, 32'd3);
        apb_write(32'h0, 32'h0000_0007);
        apb_read(32'h8, rs, ra, slv);
        check("seq_3", rs, 32'd3);
        check("seq_2", ra, 32'd2);
        apb_read(32'h8, rs, ra, slv);
        check("seq_1", rs, 32'd1);
        check("seq_0", ra, 32'd0);
        apb_read(32'h8, rs, ra, slv);
        check("seq_reload", rs, 32'd3);
        @(negedge H_CLK);
        check("irq_on", {31'd0, TIMER_IRQ}, 32'd1);
        @(posedge H_CLK); #1;
        apb_write(32'h0, 32'h0000_0004);
        apb_write(32'hC, 32'd1);
        bus_idle(2);
        @(negedge H_CLK);
        check("irq_off", {31'd0, TIMER_IRQ}, 32'd0);
        @(posedge H_CLK); #1;

        // 3: PRESCALE=4, one-shot from COUNT=1
        apb_write(32'hC, 32'd3);
        apb_write(32'h8, 32'd1);
        apb_write(32'h0, 32'h0000_0405);
        apb_read(32'h8, rs, ra, slv);
        check("ps_hold_a", rs, 32'd1);
        check("ps_hold_b", ra, 32'd1);
        bus_idle(2);
        apb_read(32'h8, rs, ra, slv);
        check("ps_before", rs, 32'd1);
        check("ps_fifth", ra, 32'd0);
        bus_idle(20);
        apb_read(32'h0, rs, ra, slv);
        check("oneshot_ctrl", rs, 32'h0000_0404);
        apb_read(32'h8, rs, ra, slv);
        check("oneshot_count", rs, 32'd0);
        apb_read(32'hC, rs, ra, slv);
        check("oneshot_pend", rs, 32'd1);

        // 4: COUNT write beats tick; hardware set beats W1C
        apb_write(32'hC, 32'd3);
        apb_write(32'h8, 32'h100);
        apb_write(32'h0, 32'h0000_0001);
        apb_write(32'h8, 32'h55);
        apb_read(32'h8, rs, ra, slv);
        check("count_override", rs, 32'h55);
        apb_write(32'h0, 32'd0);
        apb_write(32'h4, 32'd0);
        apb_write(32'h8, 32'd0);
        apb_write(32'h0, 32'h0000_0003);
        apb_write(32'hC, 32'd1);
        apb_read(32'hC, rs, ra, slv);
        check("set_beats_w1c", rs, 32'd1);
        apb_write(32'h0, 32'd0);
        apb_write(32'hC, 32'd3);
        apb_read(32'hC, rs, ra, slv);
        check("w1c_clear", rs, 32'd0);

        // 5: unmapped access and protocol errors
        apb_read(32'h18, rs, ra, slv);
        check("unmapped_rd", ra, 32'd0);
        check("unmapped_err", {31'd0, slv}, 32'd1);
        apb_write(32'h18, 32'hFFFF_FFFF);
        bus_idle(1);
        P_SELx = 1'b1; P_ENABLE = 1'b1; P_WRITE = 1'b1; P_ADDR = 32'h4; P_WDATA = 32'h77;
        @(posedge H_CLK); #1;
        bus_idle(1);
        apb_read(32'hC, rs, ra, slv);
        check("perr_idle", rs, 32'd2);
        apb_read(32'h4, rs, ra, slv);
        check("perr_drop", rs, 32'd0);
        apb_write(32'hC, 32'd2);
        P_SELx = 1'b1; P_ENABLE = 1'b0; P_WRITE = 1'b1; P_ADDR = 32'h4; P_WDATA = 32'h99;
        @(posedge H_CLK); #1;
        P_ENABLE = 1'b1; P_ADDR = 32'h8;
        @(posedge H_CLK); #1;
        bus_idle(1);
        apb_read(32'hC, rs, ra, slv);
        check("perr_addr", rs, 32'd2);
        apb_read(32'h8, rs, ra, slv);
        check("perr_addr_drop", rs, 32'd0);

        // 6: reset between setup and access
        P_SELx = 1'b1; P_ENABLE = 1'b0; P_WRITE = 1'b1; P_ADDR = 32'h0; P_WDATA = 32'h7;
        @(posedge H_CLK); #1;
        P_ENABLE = 1'b1; H_RESET = 1'b1;
        @(posedge H_CLK); #1;
        H_RESET = 1'b0;
        bus_idle(1);
        apb_read(32'h0, rs, ra, slv);
        check("rst_ctrl", rs, 32'd0);
        apb_read(32'hC, rs, ra, slv);
        check("rst_status", rs, 32'd0);
        apb_write(32'h0, 32'h0000_0300);
        apb_read(32'h0, rs, ra, slv);
        check("post_rst_ctrl", rs, 32'h0000_0300);

        bus_idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
